// File: rtl/int_to_fp_seq_if.sv
`default_nettype none
// ============================================================================
// int_to_fp_seq_if : operand/result handshake bundle for int_to_fp_seq
// Rev 1.0
// ============================================================================
interface int_to_fp_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] INPUT;
  logic        SP_DP;
  logic        Signed_Unsigned;
  logic [2:0]  Rounding_Mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] OUTPUT;
  logic        INEXACT;

  modport master (
    output in_valid, INPUT, SP_DP, Signed_Unsigned, Rounding_Mode, out_ready,
    input  in_ready, out_valid, OUTPUT, INEXACT
  );

  modport slave (
    input  in_valid, INPUT, SP_DP, Signed_Unsigned, Rounding_Mode, out_ready,
    output in_ready, out_valid, OUTPUT, INEXACT
  );
endinterface
`default_nettype wire

// File: rtl/int_to_fp_seq.sv
`default_nettype none
// ============================================================================
// int_to_fp_seq : iterative 32-bit integer to IEEE-754 single/double converter
//                 (fcvt.s.w/wu, fcvt.d.w/wu). FAST_NORM_EN selects one-cycle
//                 normalisation via a priority encoder.
// Rev 1.0
// ============================================================================
module int_to_fp_seq #(
  parameter int BIAS_SP = 127,
  parameter int BIAS_DP = 1023
) (
  input  wire              clk,
  input  wire              rst_n,
  int_to_fp_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        dp_q, dp_d;
  logic [2:0]  rm_q, rm_d;
  logic [63:0] out_q, out_d;
  logic        inexact_q, inexact_d;
  logic        out_valid_q, out_valid_d;

  logic        w_l, w_g, w_r, w_s, w_inc;
  logic [24:0] w_sum;
  logic [7:0]  w_sp_exp;
  logic [10:0] w_dp_exp;
  logic [31:0] w_sp_res;
  logic [63:0] w_dp_res;
`ifdef FAST_NORM_EN
  logic [4:0]  w_lz;
`endif

  assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.OUTPUT    = out_q;
  assign bus.INEXACT   = inexact_q;

  always_comb begin
    w_l = mag_q[8];
    w_g = mag_q[7];
    w_r = mag_q[6];
    w_s = |mag_q[5:0];
    case (rm_q)
      3'b000:  w_inc = w_g & (w_l | w_r | w_s);
      3'b010:  w_inc = sign_q & (w_g | w_r | w_s);
      3'b011:  w_inc = ~sign_q & (w_g | w_r | w_s);
      3'b100:  w_inc = w_g;
      default: w_inc = 1'b0;
    endcase
    w_sum    = {1'b0, mag_q[31:8]} + {24'd0, w_inc};
    // A carry out of the 24-bit significand leaves an all-zero fraction.
    w_sp_exp = 8'(BIAS_SP) + {3'd0, exp_q} + {7'd0, w_sum[24]};
    w_sp_res = {sign_q, w_sp_exp, (w_sum[24] ? 23'd0 : w_sum[22:0])};
    w_dp_exp = 11'(BIAS_DP) + {6'd0, exp_q};
    w_dp_res = {sign_q, w_dp_exp, mag_q[30:0], 21'd0};
  end

`ifdef FAST_NORM_EN
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_q[i]) w_lz = 5'(31 - i);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    dp_d        = dp_q;
    rm_d        = rm_q;
    out_d       = out_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mag_d   = bus.INPUT;
          sign_d  = ~bus.Signed_Unsigned & bus.INPUT[31];
          dp_d    = bus.SP_DP;
          rm_d    = bus.Rounding_Mode;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        mag_d   = sign_q ? (~mag_q + 32'd1) : mag_q;
        exp_d   = 5'd31;
        // Zero skips normalisation; ROUND turns it into +0.
        state_d = (mag_d == 32'd0) ? S_ROUND : S_NORM;
      end
      S_NORM: begin
`ifdef FAST_NORM_EN
        mag_d   = mag_q << w_lz;
        exp_d   = 5'd31 - w_lz;
        state_d = S_ROUND;
`else
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end
`endif
      end
      S_ROUND: begin
        if (mag_q == 32'd0) begin
          out_d     = dp_q ? 64'd0 : 64'hFFFF_FFFF_0000_0000;
          inexact_d = 1'b0;
        end else if (dp_q) begin
          out_d     = w_dp_res;
          inexact_d = 1'b0;
        end else begin
          out_d     = {32'hFFFF_FFFF, w_sp_res};
          inexact_d = w_g | w_r | w_s;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mag_q       <= 32'd0;
      exp_q       <= 5'd0;
      sign_q      <= 1'b0;
      dp_q        <= 1'b0;
      rm_q        <= 3'd0;
      out_q       <= 64'd0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      dp_q        <= dp_d;
      rm_q        <= rm_d;
      out_q       <= out_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp_seq.sv
`default_nettype none
// ============================================================================
// tb_int_to_fp_seq : directed-vector bench for int_to_fp_seq
// Rev 1.0
// ============================================================================
module tb_int_to_fp_seq;

`ifdef FAST_NORM_EN
  localparam bit c_fast = 1'b1;
`else
  localparam bit c_fast = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  int_to_fp_seq_if bus();

  int_to_fp_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_nz(input int lz);
    return c_fast ? 3 : lz + 3;
  endfunction

  task automatic start(input logic [31:0] val, input logic dp, input logic uns,
                       input logic [2:0] rm);
    bus.INPUT           = val;
    bus.SP_DP           = dp;
    bus.Signed_Unsigned = uns;
    bus.Rounding_Mode   = rm;
    bus.in_valid        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (!bus.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run(input string tag, input logic [31:0] val, input logic dp,
                     input logic uns, input logic [2:0] rm, input logic [63:0] exp_out,
                     input logic exp_inx, input int exp_lat);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    start(val, dp, uns, rm);
    wait_valid(tag, exp_lat);
    check({tag, "_out"}, bus.OUTPUT, exp_out);
    check({tag, "_inx"}, 64'(bus.INEXACT), 64'(exp_inx));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_vld_clr"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    bus.in_valid        = 1'b0;
    bus.INPUT           = 32'd0;
    bus.SP_DP           = 1'b0;
    bus.Signed_Unsigned = 1'b0;
    bus.Rounding_Mode   = 3'd0;
    bus.out_ready       = 1'b0;
    rst_n               = 1'b0;
    repeat (3) tick();
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    check("rst_out", bus.OUTPUT, 64'd0);
    check("rst_inx", 64'(bus.INEXACT), 64'd0);
    check("rst_rdy", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_rdy", 64'(bus.in_ready), 64'd1);

    run("sp_one",      32'h0000_0001, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_3F80_0000, 1'b0, lat_nz(31));
    run("sp_min_rne",  32'h8000_0000, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_CF00_0000, 1'b0, 3);
    run("sp_min_rdn",  32'h8000_0000, 1'b0, 1'b0, 3'b010, 64'hFFFF_FFFF_CF00_0000, 1'b0, 3);
    run("sp_umax_rne", 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b000, 64'hFFFF_FFFF_4F80_0000, 1'b1, 3);
    run("sp_umax_rz",  32'hFFFF_FFFF, 1'b0, 1'b1, 3'b001, 64'hFFFF_FFFF_4F7F_FFFF, 1'b1, 3);
    run("sp_tie_rne",  32'h0100_0001, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_4B80_0000, 1'b1, lat_nz(7));
    run("sp_tie_rup",  32'h0100_0001, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_4B80_0001, 1'b1, lat_nz(7));
    run("sp_tie_rmm",  32'h0100_0001, 1'b0, 1'b0, 3'b100, 64'hFFFF_FFFF_4B80_0001, 1'b1, lat_nz(7));
    run("sp_tie_rdn",  32'h0100_0001, 1'b0, 1'b0, 3'b010, 64'hFFFF_FFFF_4B80_0000, 1'b1, lat_nz(7));
    run("sp_tie_m7",   32'h0100_0001, 1'b0, 1'b0, 3'b111, 64'hFFFF_FFFF_4B80_0000, 1'b1, lat_nz(7));
    run("sp_neg_rdn",  32'hFEFF_FFFF, 1'b0, 1'b0, 3'b010, 64'hFFFF_FFFF_CB80_0001, 1'b1, lat_nz(7));
    run("sp_neg_rup",  32'hFEFF_FFFF, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_CB80_0000, 1'b1, lat_nz(7));
    run("dp_m1",       32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 64'hBFF0_0000_0000_0000, 1'b0, lat_nz(31));
    run("dp_umax",     32'hFFFF_FFFF, 1'b1, 1'b1, 3'b001, 64'h41EF_FFFF_FFE0_0000, 1'b0, 3);
    run("dp_zero",     32'h0000_0000, 1'b1, 1'b0, 3'b000, 64'h0000_0000_0000_0000, 1'b0, 2);
    run("sp_zero",     32'h0000_0000, 1'b0, 1'b1, 3'b000, 64'hFFFF_FFFF_0000_0000, 1'b0, 2);

    // Back-pressure: result must hold and new operands must be refused.
    start(32'h0000_0003, 1'b0, 1'b0, 3'b000);
    wait_valid("hold", lat_nz(30));
    held = bus.OUTPUT;
    check("hold_first", held, 64'hFFFF_FFFF_4040_0000);
    bus.INPUT    = 32'h1234_5678;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_out", bus.OUTPUT, 64'hFFFF_FFFF_4040_0000);
      check("hold_rdy", 64'(bus.in_ready), 64'd0);
      check("hold_vld", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hold_idle_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    check("hold_no_accept", 64'(bus.in_ready), 64'd1);

    // Reset during normalisation abandons the conversion.
    start(32'h0000_0001, 1'b0, 1'b0, 3'b000);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out", bus.OUTPUT, 64'd0);
    check("mid_rst_rdy", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_vld", 64'(bus.out_valid), 64'd0);
    run("post_rst", 32'h0000_0005, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_40A0_0000, 1'b0, lat_nz(29));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
